mean_sum_feeder: RTL and testbench
==================================

Name: mean_sum_feeder

Overview:
- Upstream stage of the sequential divider.
- Accepts a stream of unsigned samples grouped by a last flag and accumulates each group's sum and sample count.
- Presents the group as a dividend/divisor pair, so the divider produces the group mean (quotient) and residue (remainder).
- Holds the pair with a valid/ready handshake until the divider side takes it; guarantees divisor is never zero.

Parameters:
- DATA_W, 4, width of each input sample (unsigned).
- OUT_W, 4, width of dividend and divisor outputs; matches the divider operand width.
- SUM_W, DATA_W+OUT_W, internal accumulator width; sized so that (2^OUT_W-1) max-value samples never overflow internally.

Ports:
- clk  in  1  rising-edge clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  sample present on in_data.
- in_data  in  DATA_W  unsigned sample.
- in_last  in  1  qualifies in_data as the final sample of the current group.
- in_ready  out  1  block can accept a sample this cycle.
- out_valid  out  1  dividend/divisor pair is valid.
- out_ready  in  1  consumer takes the pair this cycle.
- dividend  out  OUT_W  group sum, saturated to 2^OUT_W-1.
- divisor  out  OUT_W  group sample count, range 1..2^OUT_W-1.
- ovf  out  1  group sum exceeded 2^OUT_W-1 and dividend was saturated.
- trunc  out  1  group closed by count limit, not by in_last.

Behaviour:
- Reset: on a clk edge with rst=1, all of the following take effect and any partial group is discarded.
  - State goes to ACCUM.
  - Accumulator and count are cleared.
  - in_ready=1, out_valid=0.
  - dividend=0, divisor=0, ovf=0, trunc=0.
- Accept rule: a sample is taken on an edge where in_valid=1 and in_ready=1. Only in_data and in_last are sampled then.
- State ACCUM:
  - in_ready=1, out_valid=0.
  - On each accepted beat: sum_next = sum + in_data and cnt_next = cnt + 1.
  - The group closes if in_last=1 or cnt_next == 2^OUT_W-1.
  - On close:
    - Register dividend = min(sum_next, 2^OUT_W-1).
    - ovf = (sum_next > 2^OUT_W-1).
    - divisor = cnt_next.
    - trunc = (in_last==0).
    - Clear sum and cnt; go to HOLD.
- State HOLD:
  - in_ready=0, out_valid=1.
  - dividend, divisor, ovf and trunc are held stable.
  - On an edge with out_ready=1: out_valid drops and state returns to ACCUM; in_ready=1 from the next cycle.
  - No same-cycle bypass into a new group.
- Latency: the closing beat accepted at edge N gives out_valid=1 after edge N. Minimum group-to-group spacing is 2 cycles (close, handoff).
- Empty group: impossible; a group needs at least one accepted beat, so divisor is never 0.
- in_valid=0 in ACCUM: hold all state indefinitely.
- out_ready while out_valid=0: ignored.
- Arithmetic: unsigned only. The accumulator never wraps (SUM_W sizing). Saturation is applied only at the output register.
- Reset overrides all other activity in the same cycle.

Decomposition:
- Shared package:
  - State encoding constants: ACCUM=1'b0, HOLD=1'b1.
  - Derived constant MAX_CNT = 2^OUT_W-1, reused by the divider bench for operand range checks.
- One natural sub-module: sat_narrow, a combinational SUM_W-to-OUT_W saturating narrower that also outputs the ovf bit. All other logic stays in one always block with a two-state FSM.

Test Plan:
- Group 3,4,5, in_last on 5, out_ready=1 -> dividend=12, divisor=3, ovf=0, trunc=0; out_valid high exactly 1 cycle after the beat carrying 5.
- Group 8,9 (last) -> sum 17 gives dividend=15, divisor=2, ovf=1, trunc=0.
- Single beat 0 with in_last=1 -> dividend=0, divisor=1, ovf=0; divider-side check: quotient 0, remainder 0.
- 15 beats of 1, in_last never set -> forced close on the 15th beat; dividend=15, divisor=15, trunc=1, ovf=0; the 16th beat starts a new group.
- Backpressure: hold out_ready=0 for 5 cycles after close while in_valid=1 -> in_ready=0, outputs unchanged each cycle, no beat consumed; raise out_ready -> next beat accepted the following cycle.
- Reset mid-group after beats 7,7 -> next group 2 (last) gives dividend=2, divisor=1. Also assert rst in HOLD -> out_valid=0 on the next edge and all outputs 0.

Source files
------------

// File: rtl/mean_sum_feeder_pkg.sv
// Shared definitions for the mean/sum feeder that sits in front of the sequential divider.
// The divider bench also reuses MAX_CNT for its operand range checks.
package mean_sum_feeder_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

  localparam int DEF_DATA_W = 4;
  localparam int DEF_OUT_W  = 4;

  // Largest value an unsigned field of width w can hold.
  function automatic int max_of(input int w);
    return (1 << w) - 1;
  endfunction

  localparam int MAX_CNT = max_of(DEF_OUT_W);

endpackage

// File: rtl/mean_sum_feeder_if.sv
// Sample stream in, dividend/divisor pair out; slave is the feeder, master is its environment.
interface mean_sum_feeder_if
  import mean_sum_feeder_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int OUT_W  = DEF_OUT_W
) ();

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              in_ready;
  logic              out_valid;
  logic              out_ready;
  logic [OUT_W-1:0]  dividend;
  logic [OUT_W-1:0]  divisor;
  logic              ovf;
  logic              trunc;

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, dividend, divisor, ovf, trunc
  );

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, dividend, divisor, ovf, trunc
  );

endinterface

// File: rtl/mean_sum_feeder_sat_narrow.sv
// Combinational saturating narrower: clamps a wide unsigned sum to OUT_W bits and flags the clamp.
module sat_narrow
  import mean_sum_feeder_pkg::*;
#(
  parameter int SUM_W = DEF_DATA_W + DEF_OUT_W,
  parameter int OUT_W = DEF_OUT_W
) (
  input  logic [SUM_W-1:0] sum,
  output logic [OUT_W-1:0] narrow,
  output logic             ovf
);

  localparam logic [SUM_W-1:0] LIMIT_WIDE = SUM_W'(max_of(OUT_W));
  localparam logic [OUT_W-1:0] LIMIT      = OUT_W'(max_of(OUT_W));

  // NOTE: every output is assigned on every path through always_comb, so no latch is inferred.
  always_comb begin
    ovf    = (sum > LIMIT_WIDE);
    narrow = ovf ? LIMIT : sum[OUT_W-1:0];
  end

endmodule

// File: rtl/mean_sum_feeder.sv
// Accumulates each last-delimited group of samples and holds its sum/count pair for the divider
// until the divider side accepts it; groups are force-closed when the count reaches its limit.
module mean_sum_feeder
  import mean_sum_feeder_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int OUT_W  = DEF_OUT_W,
  parameter int SUM_W  = DATA_W + OUT_W
) (
  input  logic             clk,
  input  logic             rst,
  mean_sum_feeder_if.slave bus
);

  localparam logic [OUT_W-1:0] CNT_LIMIT = OUT_W'(max_of(OUT_W));

  state_e           state;
  logic [SUM_W-1:0] sum;
  logic [OUT_W-1:0] cnt;

  logic             in_ready_q;
  logic             out_valid_q;
  logic [OUT_W-1:0] dividend_q;
  logic [OUT_W-1:0] divisor_q;
  logic             ovf_q;
  logic             trunc_q;

  logic [SUM_W-1:0] sum_next;
  logic [OUT_W-1:0] cnt_next;
  logic [OUT_W-1:0] sat_sum;
  logic             sat_ovf;
  logic             closing;

  assign sum_next = sum + SUM_W'(bus.in_data);
  assign cnt_next = cnt + OUT_W'(1);
  assign closing  = bus.in_last || (cnt_next == CNT_LIMIT);

  sat_narrow #(
    .SUM_W (SUM_W),
    .OUT_W (OUT_W)
  ) u_sat_narrow (
    .sum    (sum_next),
    .narrow (sat_sum),
    .ovf    (sat_ovf)
  );

  // NOTE: all state is assigned with non-blocking <= so every register updates from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ACCUM;
      sum         <= '0;
      cnt         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      dividend_q  <= '0;
      divisor_q   <= '0;
      ovf_q       <= 1'b0;
      trunc_q     <= 1'b0;
    end else begin
      unique case (state)
        ACCUM: begin
          // in_ready is always high in ACCUM, so in_valid alone qualifies a beat.
          if (bus.in_valid) begin
            if (closing) begin
              dividend_q  <= sat_sum;
              ovf_q       <= sat_ovf;
              divisor_q   <= cnt_next;
              trunc_q     <= ~bus.in_last;
              sum         <= '0;
              cnt         <= '0;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
              state       <= HOLD;
            end else begin
              sum <= sum_next;
              cnt <= cnt_next;
            end
          end
        end
        HOLD: begin
          // Handoff only; the next group's first beat is taken one cycle later.
          if (bus.out_ready) begin
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            state       <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.dividend  = dividend_q;
  assign bus.divisor   = divisor_q;
  assign bus.ovf       = ovf_q;
  assign bus.trunc     = trunc_q;

endmodule

// File: tb/tb_mean_sum_feeder.sv
// Directed and randomized groups checked against a group-level model: expected outputs come
// from summing and counting each whole group of samples, then clamping.
module tb_mean_sum_feeder;

  logic clk;
  logic rst;

  mean_sum_feeder_if #(.DATA_W(4), .OUT_W(4)) bus ();

  mean_sum_feeder #(.DATA_W(4), .OUT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int q[$];
  int g_use_last;
  int g_len;
  int g_hold;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
    check({tag, ".out_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, ".dividend"}, 32'(bus.dividend), 32'd0);
    check({tag, ".divisor"}, 32'(bus.divisor), 32'd0);
    check({tag, ".ovf"}, 32'(bus.ovf), 32'd0);
    check({tag, ".trunc"}, 32'(bus.trunc), 32'd0);
  endtask

  // Feed the samples in q as one group, check the closing pair, apply hold cycles of
  // backpressure (with a pending beat offered), then optionally hand the pair off.
  task automatic run_group(input string tag, input bit use_last, input int hold,
                           input bit handoff, input bit gaps);
    int exp_sum;
    int exp_len;
    exp_sum = 0;
    foreach (q[i]) exp_sum += q[i];
    exp_len = q.size();
    for (int i = 0; i < exp_len; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        bus.in_valid = 1'b0;
        step();
        check({tag, ".idle_valid"}, 32'(bus.out_valid), 32'd0);
      end
      bus.in_valid = 1'b1;
      bus.in_data  = 4'(q[i]);
      bus.in_last  = use_last && (i == exp_len - 1);
      check({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
      check({tag, ".pre_valid"}, 32'(bus.out_valid), 32'd0);
      step();
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    check({tag, ".out_valid"}, 32'(bus.out_valid), 32'd1);
    check({tag, ".dividend"}, 32'(bus.dividend), 32'((exp_sum > 15) ? 15 : exp_sum));
    check({tag, ".divisor"}, 32'(bus.divisor), 32'(exp_len));
    check({tag, ".ovf"}, 32'(bus.ovf), 32'(exp_sum > 15));
    check({tag, ".trunc"}, 32'(bus.trunc), 32'(!use_last));
    for (int h = 0; h < hold; h++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 4'd15;
      step();
      check({tag, ".bp_in_ready"}, 32'(bus.in_ready), 32'd0);
      check({tag, ".bp_out_valid"}, 32'(bus.out_valid), 32'd1);
      check({tag, ".bp_dividend"}, 32'(bus.dividend), 32'((exp_sum > 15) ? 15 : exp_sum));
      check({tag, ".bp_divisor"}, 32'(bus.divisor), 32'(exp_len));
    end
    bus.in_valid = 1'b0;
    if (handoff) begin
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
      check({tag, ".done_valid"}, 32'(bus.out_valid), 32'd0);
      check({tag, ".done_ready"}, 32'(bus.in_ready), 32'd1);
    end
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    step();
    // Stray out_ready during reset must have no effect.
    bus.out_ready = 1'b1;
    step();
    check_all_zero("reset");
    bus.out_ready = 1'b0;
    rst = 1'b0;

    // out_ready while nothing is valid is ignored.
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check_all_zero("idle_ready");

    q = '{3, 4, 5};
    run_group("g345", 1'b1, 0, 1'b1, 1'b0);

    q = '{8, 9};
    run_group("g89", 1'b1, 0, 1'b1, 1'b0);

    q = '{0};
    run_group("g0", 1'b1, 0, 1'b0, 1'b0);
    check("g0.quotient", 32'(int'(bus.dividend) / int'(bus.divisor)), 32'd0);
    check("g0.remainder", 32'(int'(bus.dividend) % int'(bus.divisor)), 32'd0);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;

    // Forced close on the 15th beat, then the next beat begins a fresh group.
    q.delete();
    for (int i = 0; i < 15; i++) q.push_back(1);
    run_group("g1x15", 1'b0, 0, 1'b1, 1'b0);
    q = '{2};
    run_group("after15", 1'b1, 0, 1'b1, 1'b0);

    // Backpressure for 5 cycles with a beat pending; it must not be absorbed.
    q = '{1, 2};
    run_group("bp", 1'b1, 5, 1'b1, 1'b0);
    q = '{6};
    run_group("after_bp", 1'b1, 0, 1'b1, 1'b0);

    // Reset mid-group discards the partial sum.
    bus.in_valid = 1'b1;
    bus.in_data  = 4'd7;
    step();
    step();
    bus.in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_all_zero("rst_mid");
    q = '{2};
    run_group("after_rst", 1'b1, 0, 1'b0, 1'b0);

    // Reset while holding a pair, with out_ready low.
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_all_zero("rst_hold");

    // Randomized groups, idle gaps and backpressure.
    for (int g = 0; g < 30; g++) begin
      g_use_last = ($urandom_range(0, 4) != 0) ? 1 : 0;
      g_len      = (g_use_last != 0) ? int'($urandom_range(1, 15)) : 15;
      g_hold     = int'($urandom_range(0, 3));
      q.delete();
      for (int i = 0; i < g_len; i++) q.push_back(int'($urandom_range(0, 15)));
      run_group("rand", g_use_last != 0, g_hold, 1'b1, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
